// File: rtl/param_seq_processor.sv
// ============================================================================
// Module   : param_seq_processor
// Purpose  : Parametrised multicycle processor core with PC, synchronous imem
//            interface, zero flag and debug register read port.
//            Optional jnz instruction is enabled by defining macro JNZ_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_seq_processor #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int IMEM_AW  = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic [DATA_W-1:0]           din,
  output logic [IMEM_AW-1:0]          addr,
  output logic                        done,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
  output logic [DATA_W-1:0]           dbg_data
);

  localparam int RW  = $clog2(NUM_REGS);
  localparam int IRW = 2*RW + 3;

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FETCH = 3'd1;
  localparam logic [2:0] c_LOAD  = 3'd2;
  localparam logic [2:0] c_EX1   = 3'd3;
  localparam logic [2:0] c_EX2   = 3'd4;
  localparam logic [2:0] c_EX3   = 3'd5;
  localparam logic [2:0] c_DONE  = 3'd6;

  localparam logic [2:0] c_OP_MV   = 3'b000;
  localparam logic [2:0] c_OP_MVI  = 3'b001;
  localparam logic [2:0] c_OP_ADD  = 3'b010;
  localparam logic [2:0] c_OP_SUB  = 3'b011;
  localparam logic [2:0] c_OP_AND  = 3'b100;
  localparam logic [2:0] c_OP_MVNZ = 3'b101;
  localparam logic [2:0] c_OP_JNZ  = 3'b110;

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [IMEM_AW-1:0] r_pc;
  logic [IRW-1:0]     r_ir;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_g;
  logic               r_z;
  logic [DATA_W-1:0]  r_regs [NUM_REGS];

  logic [2:0]         w_op;
  logic [RW-1:0]      w_rx;
  logic [RW-1:0]      w_ry;
  logic [DATA_W-1:0]  w_rx_val;
  logic [DATA_W-1:0]  w_ry_val;
  logic [DATA_W-1:0]  w_alu;
  logic               w_is_alu;

  logic               w_ir_ld;
  logic               w_pc_inc;
  logic               w_pc_jmp;
  logic               w_a_ld;
  logic               w_g_ld;
  logic               w_reg_we;
  logic [DATA_W-1:0]  w_reg_wd;
  logic               w_done;

  // Only the decoded low bits of the instruction word are kept.
  assign w_op     = r_ir[2*RW+2:2*RW];
  assign w_rx     = r_ir[2*RW-1:RW];
  assign w_ry     = r_ir[RW-1:0];
  assign w_rx_val = r_regs[w_rx];
  assign w_ry_val = r_regs[w_ry];
  assign w_is_alu = (w_op == c_OP_ADD) || (w_op == c_OP_SUB) || (w_op == c_OP_AND);

  assign addr     = r_pc;
  assign done     = w_done;
  assign dbg_data = r_regs[dbg_sel];

  always_comb begin
    w_alu = '0;
    case (w_op)
      c_OP_ADD: w_alu = r_a + w_ry_val;
      c_OP_SUB: w_alu = r_a - w_ry_val;
      c_OP_AND: w_alu = r_a & w_ry_val;
      default:  w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  w_next = run ? c_FETCH : c_IDLE;
      c_FETCH: w_next = c_LOAD;
      c_LOAD:  w_next = c_EX1;
      c_EX1:   w_next = ((w_op == c_OP_MVI) || w_is_alu) ? c_EX2 : c_DONE;
      c_EX2:   w_next = (w_op == c_OP_MVI) ? c_DONE : c_EX3;
      c_EX3:   w_next = c_DONE;
      c_DONE:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_ir_ld  = 1'b0;
    w_pc_inc = 1'b0;
    w_pc_jmp = 1'b0;
    w_a_ld   = 1'b0;
    w_g_ld   = 1'b0;
    w_reg_we = 1'b0;
    w_reg_wd = '0;
    w_done   = 1'b0;
    case (r_state)
      c_LOAD: begin
        w_ir_ld  = 1'b1;
        w_pc_inc = 1'b1;
      end
      c_EX1: begin
        case (w_op)
          c_OP_MV: begin
            w_reg_we = 1'b1;
            w_reg_wd = w_ry_val;
          end
          c_OP_MVNZ: begin
            w_reg_we = ~r_z;
            w_reg_wd = w_ry_val;
          end
          c_OP_ADD, c_OP_SUB, c_OP_AND: w_a_ld = 1'b1;
`ifdef JNZ_EN
          c_OP_JNZ: w_pc_jmp = ~r_z;
`else
          c_OP_JNZ: w_pc_jmp = 1'b0;
`endif
          default: ;
        endcase
      end
      c_EX2: begin
        if (w_op == c_OP_MVI) begin
          // Immediate word was addressed in EX1 and arrives now.
          w_reg_we = 1'b1;
          w_reg_wd = din;
          w_pc_inc = 1'b1;
        end else begin
          w_g_ld = 1'b1;
        end
      end
      c_EX3: begin
        w_reg_we = 1'b1;
        w_reg_wd = r_g;
      end
      c_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= '0;
      r_ir <= '0;
      r_a  <= '0;
      r_g  <= '0;
      r_z  <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_ir_ld) begin
        r_ir <= din[IRW-1:0];
      end
      if (w_pc_inc) begin
        r_pc <= r_pc + 1'b1;
      end else if (w_pc_jmp) begin
        r_pc <= w_ry_val[IMEM_AW-1:0];
      end
      if (w_a_ld) begin
        r_a <= w_rx_val;
      end
      if (w_g_ld) begin
        r_g <= w_alu;
        r_z <= (w_alu == '0);
      end
      if (w_reg_we) begin
        r_regs[w_rx] <= w_reg_wd;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_param_seq_processor.sv
// ============================================================================
// Module   : tb_param_seq_processor
// Purpose  : Directed self-checking bench for param_seq_processor with a ROM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_seq_processor;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVNZ = 3'b101;
  localparam logic [2:0] OP_JNZ  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        run     = 1'b0;
  logic [15:0] din     = '0;
  logic [4:0]  addr;
  logic        done;
  logic [2:0]  dbg_sel = '0;
  logic [15:0] dbg_data;

  logic [15:0] rom [32];
  int n_checks = 0;
  int n_fail   = 0;

  param_seq_processor #(
    .DATA_W  (16),
    .NUM_REGS(8),
    .IMEM_AW (5)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .din     (din),
    .addr    (addr),
    .done    (done),
    .dbg_sel (dbg_sel),
    .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one-cycle read latency
  always @(posedge clk) din <= rom[addr];

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rx,
                                      input logic [2:0] ry);
    return {7'd0, op, rx, ry};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input int r, input logic [15:0] exp);
    dbg_sel = r[2:0];
    #1;
    check(tag, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  // Issues one run pulse and returns at the negedge of the done cycle.
  task automatic run_one(input string tag, input int lat);
    int k;
    k = 0;
    @(negedge clk);
    run = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) run = 1'b0;
      if (done) begin
        k = c;
        break;
      end
    end
    check({tag, "_lat"}, k, lat);
  endtask

  initial begin
    int dk[3];
    int nd;
    int ndone;

    for (int i = 0; i < 32; i++) rom[i] = enc(OP_NOP, 3'd0, 3'd0);
    rom[0]  = enc(OP_MVI, 3'd1, 3'd0);  rom[1]  = 16'h00FF;
    rom[2]  = enc(OP_MVI, 3'd1, 3'd0);  rom[3]  = 16'h0005;
    rom[4]  = enc(OP_MVI, 3'd2, 3'd0);  rom[5]  = 16'h0007;
    rom[6]  = enc(OP_ADD, 3'd1, 3'd2);
    rom[7]  = enc(OP_SUB, 3'd1, 3'd1);
    rom[8]  = enc(OP_MVI, 3'd3, 3'd0);  rom[9]  = 16'h1234;
    rom[10] = enc(OP_MVNZ, 3'd3, 3'd1);
    rom[11] = enc(OP_MVI, 3'd5, 3'd0);  rom[12] = 16'hFFFF;
    rom[13] = enc(OP_MVI, 3'd6, 3'd0);  rom[14] = 16'h0001;
    rom[15] = enc(OP_ADD, 3'd5, 3'd6);
    rom[16] = enc(OP_MVI, 3'd1, 3'd0);  rom[17] = 16'h000C;
    rom[18] = enc(OP_MVI, 3'd2, 3'd0);  rom[19] = 16'h0006;
    rom[20] = enc(OP_AND, 3'd1, 3'd2);
    rom[21] = enc(OP_MVNZ, 3'd3, 3'd1);
    rom[22] = enc(OP_MVI, 3'd4, 3'd0);  rom[23] = 16'h001A;
    rom[24] = enc(OP_JNZ, 3'd0, 3'd4);
    rom[26] = 16'hFE00 | enc(OP_MV, 3'd7, 3'd1);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 8; r++) check_reg($sformatf("rst_R%0d", r), r, 16'h0000);
    check("rst_addr", {27'd0, addr}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    run_one("mvi_ff", 5);
    check_reg("mvi_R1", 1, 16'h00FF);
    check("mvi_addr", {27'd0, addr}, 32'd2);

    run_one("mvi_5", 5);
    run_one("mvi_7", 5);
    run_one("add", 6);
    check_reg("add_R1", 1, 16'h000C);
    run_one("sub", 6);
    check_reg("sub_R1", 1, 16'h0000);

    run_one("mvi_1234", 5);
    run_one("mvnz_z1", 4);
    check_reg("mvnz_z1_R3", 3, 16'h1234);

    run_one("mvi_ffff", 5);
    run_one("mvi_1", 5);
    run_one("add_wrap", 6);
    check_reg("add_wrap_R5", 5, 16'h0000);
    check_reg("add_wrap_R6", 6, 16'h0001);

    run_one("mvi_c", 5);
    run_one("mvi_6", 5);
    run_one("and", 6);
    check_reg("and_R1", 1, 16'h0004);
    run_one("mvnz_z0", 4);
    check_reg("mvnz_z0_R3", 3, 16'h0004);

    run_one("mvi_1a", 5);
    run_one("jnz", 4);
`ifdef JNZ_EN
    check("jnz_addr", {27'd0, addr}, 32'd26);
`else
    check("jnz_addr", {27'd0, addr}, 32'd25);
    run_one("nop25", 4);
`endif
    run_one("mv_upper", 4);
    check_reg("mv_R7", 7, 16'h0004);
    check("mv_addr", {27'd0, addr}, 32'd27);
    run_one("nop27", 4);
    run_one("nop28", 4);

    // Three nops at 29..31 with run held high; PC wraps to 0.
    dk[0] = 0; dk[1] = 0; dk[2] = 0;
    nd = 0;
    @(negedge clk);
    run = 1'b1;
    for (int c = 1; c <= 20 && nd < 3; c++) begin
      @(negedge clk);
      if (done) begin
        dk[nd] = c;
        nd++;
      end
    end
    run = 1'b0;
    check("b2b_count", nd, 3);
    check("b2b_done0", dk[0], 4);
    check("b2b_done1", dk[1], 9);
    check("b2b_done2", dk[2], 14);
    check("wrap_addr", {27'd0, addr}, 32'd0);

    // Reset while an add sits in EX2.
    rom[0] = enc(OP_ADD, 3'd7, 3'd1);
    @(negedge clk);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst_mid_done", ndone, 0);
    check_reg("rst_mid_R7", 7, 16'h0000);
    check("rst_mid_addr", {27'd0, addr}, 32'd0);

    rom[0] = enc(OP_MVI, 3'd2, 3'd0);
    rom[1] = 16'hABCD;
    run_one("post_rst_mvi", 5);
    check_reg("post_rst_R2", 2, 16'hABCD);
    check("post_rst_addr", {27'd0, addr}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
